// File: rtl/cmp_arb_pkg.sv
// rtl/cmp_arb_pkg.sv - shared types and constants for the compare arbiter
package cmp_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic REQ0  = 1'b0;
  localparam logic REQ1  = 1'b1;
  localparam int   CNT_W = 8;

endpackage

// File: rtl/cmp_arbiter_mag_cmp.sv
// rtl/cmp_arbiter_mag_cmp.sv - combinational unsigned magnitude comparator
module mag_cmp
  import cmp_arb_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             a_big,
  output logic             b_big,
  output logic             equal
);

  assign a_big = (a > b);
  assign b_big = (a < b);
  assign equal = (a == b);

endmodule

// File: rtl/cmp_arbiter.sv
// rtl/cmp_arbiter.sv - round-robin arbiter sharing one comparator between two requesters
// Optional grant statistics outputs are enabled by defining CMP_ARB_STATS_EN.
module cmp_arbiter
  import cmp_arb_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic             rsp_a_big,
  output logic             rsp_b_big,
  output logic             rsp_equal
`ifdef CMP_ARB_STATS_EN
  ,
  output logic [CNT_W-1:0] grant_cnt0,
  output logic [CNT_W-1:0] grant_cnt1
`endif
);

  state_e           state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic             id_q, id_d;
  logic [WIDTH-1:0] op_a_q, op_a_d;
  logic [WIDTH-1:0] op_b_q, op_b_d;
  logic             a_big_q, a_big_d;
  logic             b_big_q, b_big_d;
  logic             equal_q, equal_d;
  logic             grant0, grant1;
  logic             cmp_a_big, cmp_b_big, cmp_equal;

  mag_cmp #(.WIDTH(WIDTH)) u_mag_cmp (
    .a     (op_a_q),
    .b     (op_b_q),
    .a_big (cmp_a_big),
    .b_big (cmp_b_big),
    .equal (cmp_equal)
  );

  // On a tie the requester not served last wins; a lone requester always wins.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state_q == IDLE) begin
      if (req0_valid && req1_valid) begin
        grant0 = (last_grant_q == REQ1);
        grant1 = (last_grant_q == REQ0);
      end else begin
        grant0 = req0_valid;
        grant1 = req1_valid;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    id_d         = id_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    a_big_d      = a_big_q;
    b_big_d      = b_big_q;
    equal_d      = equal_q;
    case (state_q)
      IDLE: begin
        if (grant0 || grant1) begin
          id_d         = grant1 ? REQ1 : REQ0;
          last_grant_d = grant1 ? REQ1 : REQ0;
          op_a_d       = grant1 ? req1_a : req0_a;
          op_b_d       = grant1 ? req1_b : req0_b;
          state_d      = CMP;
        end
      end
      CMP: begin
        a_big_d = cmp_a_big;
        b_big_d = cmp_b_big;
        equal_d = cmp_equal;
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          a_big_d = 1'b0;
          b_big_d = 1'b0;
          equal_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= REQ1;
      id_q         <= REQ0;
      op_a_q       <= '0;
      op_b_q       <= '0;
      a_big_q      <= 1'b0;
      b_big_q      <= 1'b0;
      equal_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      id_q         <= id_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      a_big_q      <= a_big_d;
      b_big_q      <= b_big_d;
      equal_q      <= equal_d;
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign rsp_valid  = (state_q == RESP);
  assign rsp_id     = id_q;
  assign rsp_a_big  = a_big_q;
  assign rsp_b_big  = b_big_q;
  assign rsp_equal  = equal_q;

`ifdef CMP_ARB_STATS_EN
  logic [CNT_W-1:0] cnt0_q, cnt1_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      if (grant0 && (cnt0_q != {CNT_W{1'b1}})) cnt0_q <= cnt0_q + CNT_W'(1);
      if (grant1 && (cnt1_q != {CNT_W{1'b1}})) cnt1_q <= cnt1_q + CNT_W'(1);
    end
  end

  assign grant_cnt0 = cnt0_q;
  assign grant_cnt1 = cnt1_q;
`endif

endmodule

// File: tb/tb_cmp_arbiter.sv
// tb/tb_cmp_arbiter.sv - self-checking bench for cmp_arbiter against a transaction-level model
module tb_cmp_arbiter;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req0_valid = 1'b0, req1_valid = 1'b0, rsp_ready = 1'b0;
  logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic         req0_ready, req1_ready, rsp_valid, rsp_id;
  logic         rsp_a_big, rsp_b_big, rsp_equal;
`ifdef CMP_ARB_STATS_EN
  logic [7:0]   grant_cnt0, grant_cnt1;
`endif

  cmp_arbiter #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_a_big  (rsp_a_big),
    .rsp_b_big  (rsp_b_big),
    .rsp_equal  (rsp_equal)
`ifdef CMP_ARB_STATS_EN
    ,
    .grant_cnt0 (grant_cnt0),
    .grant_cnt1 (grant_cnt1)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Transaction-level model: idle, or holding one accepted job of a given age in cycles.
  bit m_busy;
  int m_age;
  bit m_last;
  bit m_rid;
  int m_a, m_b;
  int m_cnt0, m_cnt1;
  bit hold0, hold1;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick();
    if (m_busy) return -1;
    if (req0_valid && req1_valid) return m_last ? 0 : 1;
    if (req0_valid) return 0;
    if (req1_valid) return 1;
    return -1;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_age = 0; m_last = 1; m_rid = 0;
    m_a = 0; m_b = 0; m_cnt0 = 0; m_cnt1 = 0;
  endtask

  task automatic compare_outputs();
    int g;
    bit rv;
    g  = pick();
    rv = m_busy && (m_age >= 1);
    check("req0_ready", req0_ready, g == 0);
    check("req1_ready", req1_ready, g == 1);
    check("rsp_valid", rsp_valid, rv);
    if (rv) begin
      check("rsp_id", rsp_id, m_rid);
      check("rsp_a_big", rsp_a_big, m_a > m_b);
      check("rsp_b_big", rsp_b_big, m_a < m_b);
      check("rsp_equal", rsp_equal, m_a == m_b);
    end else begin
      check("flags_idle", {rsp_a_big, rsp_b_big, rsp_equal}, 0);
    end
`ifdef CMP_ARB_STATS_EN
    check("grant_cnt0", grant_cnt0, m_cnt0);
    check("grant_cnt1", grant_cnt1, m_cnt1);
`endif
  endtask

  // Called shortly after a falling edge with inputs already driven; returns at the next falling edge.
  task automatic step();
    int g;
    bit rr;
    int a0, b0, a1, b1;
    #1;
    compare_outputs();
    g  = pick();
    rr = rsp_ready;
    a0 = int'(req0_a); b0 = int'(req0_b);
    a1 = int'(req1_a); b1 = int'(req1_b);
    @(posedge clk);
    if (g >= 0) begin
      m_busy = 1; m_age = 0; m_last = g[0]; m_rid = g[0];
      m_a = (g == 1) ? a1 : a0;
      m_b = (g == 1) ? b1 : b0;
      if (g == 0) m_cnt0 = (m_cnt0 < 255) ? m_cnt0 + 1 : 255;
      else        m_cnt1 = (m_cnt1 < 255) ? m_cnt1 + 1 : 255;
    end else if (m_busy) begin
      if (m_age >= 1 && rr) m_busy = 0;
      else m_age++;
    end
    @(negedge clk);
    if (g == 0 && !hold0) req0_valid = 1'b0;
    if (g == 1 && !hold1) req1_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    #1;
    compare_outputs();
    check("rst_rsp_id", rsp_id, 0);
    rst = 1'b0;
  endtask

  initial begin
    bit ids[$];
    bit abig[$];
    bit bbig[$];
    int seen;

    hold0 = 0; hold1 = 0;
    model_reset();

    // Single request: 4 > 3 from requester 0.
    do_reset();
    req0_valid = 1; req0_a = 4'h4; req0_b = 4'h3; rsp_ready = 1;
    #1;
    check("t1_accept_ready", req0_ready, 1);
    step();
    step();
    #1;
    check("t1_rsp_valid", rsp_valid, 1);
    check("t1_rsp_id", rsp_id, 0);
    check("t1_flags", {rsp_a_big, rsp_b_big, rsp_equal}, 3'b100);
    step();
    step();

    // Tie from reset: req0 (5,B) stays valid, req1 (A,8) drops after service.
    req0_valid = 1; req0_a = 4'h5; req0_b = 4'hB;
    req1_valid = 1; req1_a = 4'hA; req1_b = 4'h8;
    hold0 = 1; rsp_ready = 1;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      #1;
      if (rsp_valid && rsp_ready) begin
        ids.push_back(rsp_id);
        abig.push_back(rsp_a_big);
        bbig.push_back(rsp_b_big);
      end
      step();
    end
    check("tie_count", ids.size() >= 3, 1);
    if (ids.size() >= 3) begin
      check("tie_id0", ids[0], 0);
      check("tie_bbig0", bbig[0], 1);
      check("tie_id1", ids[1], 1);
      check("tie_abig1", abig[1], 1);
      check("tie_id2", ids[2], 0);
    end
    hold0 = 0; req0_valid = 0; req1_valid = 0;

    // Equal operands on requester 1.
    do_reset();
    req1_valid = 1; req1_a = 4'hD; req1_b = 4'hD; rsp_ready = 1;
    step();
    step();
    #1;
    check("eq_flags", {rsp_valid, rsp_a_big, rsp_b_big, rsp_equal}, 4'b1001);
    check("eq_id", rsp_id, 1);
    step();

    // Backpressure: response held five cycles while req1 waits.
    do_reset();
    req0_valid = 1; req0_a = 4'hB; req0_b = 4'h1; rsp_ready = 0;
    step();
    req1_valid = 1; req1_a = 4'h2; req1_b = 4'h9;
    step();
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp_held", {rsp_valid, rsp_a_big, req0_ready, req1_ready}, 4'b1100);
      step();
    end
    rsp_ready = 1;
    step();
    #1;
    check("bp_released", {rsp_valid, req1_ready}, 2'b01);
    repeat (4) step();

    // Reset during RESP: outputs drop without a clock edge, nothing stale afterwards.
    do_reset();
    req0_valid = 1; req0_a = 4'h1; req0_b = 4'h2; rsp_ready = 0;
    step();
    step();
    #1;
    check("mid_rsp_valid_before", rsp_valid, 1);
    #1;
    rst = 1'b1;
    model_reset();
    #1;
    check("mid_async_clear", {rsp_valid, rsp_id, rsp_a_big, rsp_b_big, rsp_equal}, 0);
    @(negedge clk);
    rst = 1'b0;
    rsp_ready = 1;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (rsp_valid) seen++;
      step();
    end
    check("mid_no_stale", seen, 0);
    req0_valid = 1; req0_a = 4'h3; req0_b = 4'h3;
    req1_valid = 1; req1_a = 4'h7; req1_b = 4'h3;
    #1;
    check("mid_tie_req0", {req0_ready, req1_ready}, 2'b10);
    repeat (8) step();

    // Randomized traffic with random backpressure.
    req0_valid = 0; req1_valid = 0;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if (!req0_valid && $urandom_range(2) == 0) begin
        req0_valid = 1;
        req0_a = W'($urandom_range(15));
        req0_b = ($urandom_range(3) == 0) ? req0_a : W'($urandom_range(15));
      end
      if (!req1_valid && $urandom_range(2) == 0) begin
        req1_valid = 1;
        req1_a = W'($urandom_range(15));
        req1_b = ($urandom_range(3) == 0) ? req1_a : W'($urandom_range(15));
      end
      rsp_ready = ($urandom_range(3) != 0);
      step();
    end

`ifdef CMP_ARB_STATS_EN
    // 300 back-to-back requester 0 transactions saturate its counter.
    req0_valid = 0; req1_valid = 0;
    do_reset();
    hold0 = 1; req0_valid = 1; req0_a = 4'h6; req0_b = 4'h2; rsp_ready = 1;
    repeat (3 * 300 + 2) step();
    #1;
    check("stats_sat0", grant_cnt0, 8'hFF);
    check("stats_cnt1", grant_cnt1, 8'h00);
    hold0 = 0;
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
